// File: rtl/mailbox_pkg.sv
// Mailbox fabric shared definitions: message opcodes used on endpoint streams.
package mailbox_pkg;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_DATA = 4'h1;
  localparam logic [3:0] OPC_CTRL = 4'h2;

endpackage

// File: rtl/uart_pkg.sv
// UART receive shared definitions: receiver FSM states and the 3-sample
// majority vote used to decide each bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 UART deserialiser: 2-FF synchroniser, bit timer, 3-sample majority vote
// and IDLE/START/DATA/STOP FSM.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   rx           raw serial input (idle high, asynchronous)
//   byte_valid   1-cycle pulse, rx_byte holds a good byte
//   rx_byte      last assembled byte (LSB first)
//   frame_err    1-cycle pulse, stop bit decided 0
//   break_det    1-cycle pulse, frame error with all data bits 0
//   idle_tick    1-cycle pulse per bit period spent in IDLE
//   start_det    1-cycle pulse on every accepted falling edge (incl. false starts)
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       break_det,
  output logic       idle_tick,
  output logic       start_det
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned H  = BAUD_DIV / 2;
  localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);

  logic rx_meta, rx_s, rx_q;

  uart_rx_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           s0, s0_n, s1, s1_n;
  logic           byte_valid_n, frame_err_n, break_det_n, idle_tick_n, start_det_n;
  logic           start_edge, decide, bit_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign start_edge = rx_q & ~rx_s;
  assign decide     = (cnt == C_DEC);
  assign bit_val    = majority3(s0, s1, rx_s);

  // In IDLE the bit timer keeps running and doubles as the idle bit-period
  // timer; every transition into IDLE or START restarts it from zero.
  always_comb begin
    state_n      = state;
    cnt_n        = (cnt == C_LAST) ? '0 : cnt + 1'b1;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    s0_n         = (cnt == C_S0) ? rx_s : s0;
    s1_n         = (cnt == C_S1) ? rx_s : s1;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    break_det_n  = 1'b0;
    idle_tick_n  = 1'b0;
    start_det_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_n     = START;
          cnt_n       = '0;
          start_det_n = 1'b1;
        end else begin
          idle_tick_n = (cnt == C_LAST);
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == C_LAST) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (decide) shreg_n = {bit_val, shreg[7:1]};
        if (cnt == C_LAST) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-bit so a back-to-back start edge is not missed.
        if (decide) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (bit_val) begin
            byte_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            break_det_n = (shreg == 8'h00);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      idle_tick  <= 1'b0;
      start_det  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      s0         <= s0_n;
      s1         <= s1_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
      break_det  <= break_det_n;
      idle_tick  <= idle_tick_n;
      start_det  <= start_det_n;
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/uart_rx_word_packer.sv
// UART receive front-end for a mailbox endpoint: deserialises 8N1 bytes,
// packs them LSB-first into 32-bit words (flushing partial words after an
// idle timeout) and queues them as single-beat OPC_DATA messages.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   UART_RX / UART_RTS serial input / flow control (1 = peer may send)
//   cfg_dest           destination captured with each pushed word
//   tx_*               mailbox TX stream (valid/ready, head word fall-through)
//   frame_err, break_det, overrun   1-cycle status pulses
module uart_rx_word_packer
  import uart_pkg::*;
  import mailbox_pkg::*;
#(
  parameter int unsigned BAUD_DIV          = 217,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned IDLE_TIMEOUT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        UART_RX,
  output logic        UART_RTS,
  input  logic [15:0] cfg_dest,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] tx_dest,
  output logic [31:0] tx_data,
  output logic        tx_prio,
  output logic        tx_eop,
  output logic [3:0]  tx_opcode,
  output logic        frame_err,
  output logic        break_det,
  output logic        overrun
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW   = $clog2(IDLE_TIMEOUT_BITS + 1);

  logic       byte_valid, idle_tick, start_det;
  logic [7:0] rx_byte;

  uart_rx_deser #(
    .BAUD_DIV (BAUD_DIV)
  ) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (UART_RX),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .idle_tick  (idle_tick),
    .start_det  (start_det)
  );

  // Packer: lanes fill LSB-first; a push is requested one cycle after the
  // completing byte (or the timeout) and the packer clears in that cycle.
  logic [3:0][7:0] lanes;
  logic [1:0]      byte_idx;
  logic            push_pend;
  logic [TW-1:0]   tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes     <= '0;
      byte_idx  <= '0;
      push_pend <= 1'b0;
      tcnt      <= '0;
    end else if (push_pend) begin
      lanes     <= '0;
      byte_idx  <= '0;
      push_pend <= 1'b0;
      tcnt      <= '0;
    end else begin
      if (byte_valid) begin
        lanes[byte_idx] <= rx_byte;
        byte_idx        <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) push_pend <= 1'b1;
      end
      if (start_det) begin
        tcnt <= '0;
      end else if (idle_tick && byte_idx != 2'd0) begin
        if (tcnt == TW'(IDLE_TIMEOUT_BITS - 1)) begin
          push_pend <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // Word FIFO: entry = {dest, data}
  logic [47:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CNTW-1:0] count, count_n;
  logic            full, pop, push_ok;

  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign pop     = tx_valid & tx_ready;
  assign push_ok = push_pend & (~full | pop);

  always_comb begin
    count_n = count;
    case ({push_ok, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {cfg_dest, lanes};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      UART_RTS <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count    <= count_n;
      UART_RTS <= (count_n < CNTW'(FIFO_DEPTH - 1));
      overrun  <= push_pend & ~push_ok;
    end
  end

  assign tx_valid  = (count != '0);
  assign tx_data   = tx_valid ? mem[rptr][31:0]  : '0;
  assign tx_dest   = tx_valid ? mem[rptr][47:32] : '0;
  assign tx_prio   = 1'b0;
  assign tx_eop    = 1'b1;
  assign tx_opcode = OPC_DATA;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
module tb_uart_rx_word_packer;
  import mailbox_pkg::*;

  localparam int BD = 16;
  localparam int FD = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        UART_RX;
  logic        UART_RTS;
  logic [15:0] cfg_dest;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_dest;
  logic [31:0] tx_data;
  logic        tx_prio;
  logic        tx_eop;
  logic [3:0]  tx_opcode;
  logic        frame_err;
  logic        break_det;
  logic        overrun;

  uart_rx_word_packer #(
    .BAUD_DIV          (BD),
    .FIFO_DEPTH        (FD),
    .IDLE_TIMEOUT_BITS (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .UART_RX   (UART_RX),
    .UART_RTS  (UART_RTS),
    .cfg_dest  (cfg_dest),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_dest   (tx_dest),
    .tx_data   (tx_data),
    .tx_prio   (tx_prio),
    .tx_eop    (tx_eop),
    .tx_opcode (tx_opcode),
    .frame_err (frame_err),
    .break_det (break_det),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed beats and pulse counts, sampled on the falling edge
  logic [47:0] rxq[$];
  int fe_cnt = 0, bd_cnt = 0, ov_cnt = 0, bad_const = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        rxq.push_back({tx_dest, tx_data});
        if (tx_opcode !== OPC_DATA || tx_eop !== 1'b1 || tx_prio !== 1'b0) bad_const++;
      end
      if (frame_err) fe_cnt++;
      if (break_det) bd_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  // Reference model: byte stream -> LSB-first 32-bit words, last one zero-padded
  function automatic void pack_words(input logic [7:0] bytes[$], input logic [15:0] dest,
                                     output logic [47:0] words[$]);
    logic [31:0] w;
    words.delete();
    w = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      w = w + (32'(bytes[i]) << (8 * (i % 4)));
      if (i % 4 == 3 || i == bytes.size() - 1) begin
        words.push_back({dest, w});
        w = 0;
      end
    end
  endfunction

  task automatic drive_bit(input logic v);
    UART_RX = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    UART_RX = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    UART_RX = 1'b1;
    repeat (n * BD) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    UART_RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tx_ready = 1'b1;
    cfg_dest = 16'h0;
    do_reset();
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else n_pass++;
    n_checks++; if (tx_data !== 32'h0) $display("FAIL reset_tx_data: got %h expected 0", tx_data); else n_pass++;
    n_checks++; if (tx_dest !== 16'h0) $display("FAIL reset_tx_dest: got %h expected 0", tx_dest); else n_pass++;
    n_checks++; if (UART_RTS !== 1'b1) $display("FAIL reset_rts: got %b expected 1", UART_RTS); else n_pass++;
    n_checks++;
    if ({frame_err, break_det, overrun} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {frame_err, break_det, overrun});
    else n_pass++;
    n_checks++;
    if (tx_opcode !== OPC_DATA || tx_eop !== 1'b1 || tx_prio !== 1'b0)
      $display("FAIL const_fields: got op=%h eop=%b prio=%b expected op=%h eop=1 prio=0",
               tx_opcode, tx_eop, tx_prio, OPC_DATA);
    else n_pass++;
  endtask

  task automatic test_full_word();
    logic [7:0]  b[$];
    logic [47:0] exp[$];
    rxq.delete();
    bad_const = 0;
    cfg_dest = 16'h0102;
    tx_ready = 1'b1;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (b[i]) send_byte(b[i], 1'b1);
    idle_bits(2);
    pack_words(b, 16'h0102, exp);
    n_checks++; if (rxq.size() != 1) $display("FAIL full_word_count: got %0d expected 1", rxq.size()); else n_pass++;
    if (rxq.size() >= 1) begin
      n_checks++; if (rxq[0] !== exp[0]) $display("FAIL full_word_beat: got %h expected %h", rxq[0], exp[0]); else n_pass++;
    end
    n_checks++; if (bad_const != 0) $display("FAIL full_word_const: got %0d bad beats expected 0", bad_const); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [31:0] expw;
    rxq.delete();
    cfg_dest = 16'h0A0B;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    expw = (32'h5A << 8) + 32'hA5;
    idle_bits(TO - 2);
    n_checks++; if (rxq.size() != 0 || tx_valid !== 1'b0) $display("FAIL timeout_early: got %0d beats expected 0", rxq.size()); else n_pass++;
    idle_bits(4);
    n_checks++; if (rxq.size() != 1) $display("FAIL timeout_count: got %0d expected 1", rxq.size()); else n_pass++;
    if (rxq.size() >= 1) begin
      n_checks++; if (rxq[0] !== {16'h0A0B, expw}) $display("FAIL timeout_word: got %h expected %h", rxq[0], {16'h0A0B, expw}); else n_pass++;
    end
  endtask

  task automatic test_frame_errors();
    int fe0, bd0;
    rxq.delete();
    fe0 = fe_cnt; bd0 = bd_cnt;
    send_byte(8'h3C, 1'b0);
    idle_bits(2);
    n_checks++; if (fe_cnt - fe0 != 1 || bd_cnt - bd0 != 0) $display("FAIL ferr_3c: got fe=%0d bd=%0d expected fe=1 bd=0", fe_cnt - fe0, bd_cnt - bd0); else n_pass++;
    fe0 = fe_cnt; bd0 = bd_cnt;
    send_byte(8'h00, 1'b0);
    idle_bits(2);
    n_checks++; if (fe_cnt - fe0 != 1 || bd_cnt - bd0 != 1) $display("FAIL break_00: got fe=%0d bd=%0d expected fe=1 bd=1", fe_cnt - fe0, bd_cnt - bd0); else n_pass++;
    fe0 = fe_cnt;
    UART_RX = 1'b0;
    repeat (30 * BD) @(posedge clk);
    #1;
    idle_bits(2);
    n_checks++; if (fe_cnt - fe0 != 1) $display("FAIL held_low: got fe=%0d expected 1", fe_cnt - fe0); else n_pass++;
    idle_bits(TO + 4);
    n_checks++; if (rxq.size() != 0) $display("FAIL ferr_no_pack: got %0d beats expected 0", rxq.size()); else n_pass++;
  endtask

  task automatic test_glitch();
    int fe0;
    rxq.delete();
    fe0 = fe_cnt;
    UART_RX = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_bits(TO + 4);
    n_checks++; if (fe_cnt != fe0 || rxq.size() != 0) $display("FAIL glitch: got fe=%0d beats=%0d expected 0 0", fe_cnt - fe0, rxq.size()); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0]  b[$];
    logic [47:0] exp[$];
    int ov0;
    rxq.delete();
    ov0 = ov_cnt;
    tx_ready = 1'b0;
    cfg_dest = 16'($urandom);
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    pack_words(b, cfg_dest, exp);
    for (int i = 0; i < 20; i++) begin
      send_byte(b[i], 1'b1);
      if (i == 7) begin
        n_checks++; if (UART_RTS !== 1'b1) $display("FAIL rts_at_2: got %b expected 1", UART_RTS); else n_pass++;
      end
      if (i == 11) begin
        n_checks++; if (UART_RTS !== 1'b0) $display("FAIL rts_at_3: got %b expected 0", UART_RTS); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (ov_cnt != ov0) $display("FAIL no_overrun_at_4: got %0d expected 0", ov_cnt - ov0); else n_pass++;
      end
    end
    idle_bits(1);
    n_checks++; if (ov_cnt - ov0 != 1) $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt - ov0); else n_pass++;
    n_checks++; if (rxq.size() != 0 || tx_valid !== 1'b1) $display("FAIL overrun_hold: got beats=%0d valid=%b expected 0 1", rxq.size(), tx_valid); else n_pass++;
    tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (rxq.size() != 4) $display("FAIL drain_count: got %0d expected 4", rxq.size()); else n_pass++;
    for (int i = 0; i < 4 && i < rxq.size(); i++) begin
      n_checks++; if (rxq[i] !== exp[i]) $display("FAIL drain_word%0d: got %h expected %h", i, rxq[i], exp[i]); else n_pass++;
    end
    n_checks++; if (UART_RTS !== 1'b1) $display("FAIL rts_after_drain: got %b expected 1", UART_RTS); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b[$];
    logic [47:0] exp[$];
    tx_ready = 1'b0;
    cfg_dest = 16'h7777;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    n_checks++; if (tx_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", tx_valid); else n_pass++;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b0 || UART_RTS !== 1'b1) $display("FAIL async_reset: got valid=%b rts=%b expected 0 1", tx_valid, UART_RTS); else n_pass++;
    UART_RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    rxq.delete();
    idle_bits(1);
    cfg_dest = 16'h0BEE;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    pack_words(b, cfg_dest, exp);
    foreach (b[i]) send_byte(b[i], 1'b1);
    idle_bits(TO + 4);
    n_checks++; if (rxq.size() != 1) $display("FAIL post_reset_count: got %0d expected 1", rxq.size()); else n_pass++;
    if (rxq.size() >= 1) begin
      n_checks++; if (rxq[0] !== exp[0]) $display("FAIL post_reset_word: got %h expected %h", rxq[0], exp[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0]  b[$];
    logic [47:0] exp[$];
    int n;
    tx_ready = 1'b1;
    for (int it = 0; it < 3; it++) begin
      rxq.delete();
      b.delete();
      n = int'($urandom_range(4, 11));
      cfg_dest = 16'($urandom);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      pack_words(b, cfg_dest, exp);
      foreach (b[i]) begin
        send_byte(b[i], 1'b1);
        idle_bits(int'($urandom_range(0, 3)));
      end
      idle_bits(TO + 4);
      n_checks++; if (rxq.size() != exp.size()) $display("FAIL rand%0d_count: got %0d expected %0d", it, rxq.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size() && i < rxq.size(); i++) begin
        n_checks++; if (rxq[i] !== exp[i]) $display("FAIL rand%0d_word%0d: got %h expected %h", it, i, rxq[i], exp[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    UART_RX  = 1'b1;
    tx_ready = 1'b1;
    cfg_dest = 16'h0;
    test_reset();
    test_full_word();
    test_timeout();
    test_frame_errors();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
